// File: rtl/iir_inverse_if.sv
// ---------------------------------------------------------------------------
// iir_inverse_if
//   Sample stream bundle for the iir_inverse equaliser.
//   data_i  : signed filtered sample y[n] (producer -> equaliser)
//   valid_i : data_i is valid
//   ready_o : equaliser can accept a sample
//   data_o  : signed recovered sample x[n] (equaliser -> consumer)
//   valid_o : one-cycle pulse marking a new data_o
//   Modports: slave = equaliser side, master = producer/consumer side.
// ---------------------------------------------------------------------------
interface iir_inverse_if;
    logic signed [15:0] data_i;
    logic               valid_i;
    logic               ready_o;
    logic signed [15:0] data_o;
    logic               valid_o;

    modport slave (
        input  data_i,
        input  valid_i,
        output ready_o,
        output data_o,
        output valid_o
    );

    modport master (
        output data_i,
        output valid_i,
        input  ready_o,
        input  data_o,
        input  valid_o
    );
endinterface

// File: rtl/iir_inverse.sv
// ---------------------------------------------------------------------------
// iir_inverse
//   Inverse of the first-order iir section: recovers x[n] from
//   y[n] = (1+2K)x[n] + (2K-1)x[n-1] - y[n-1] using
//   x[n] = (y[n] + y[n-1] - (2K-1)x[n-1]) / (1+2K), truncated toward zero
//   and saturated to 16 bits. A 25-step restoring divider gives one result
//   per 28 cycles (27-cycle latency).
//   Parameter: TIMECONSTANT = K (1..255).
//   Ports:
//     clk_i   : clock, rising edge
//     reset_i : synchronous active-high reset
//     bus     : iir_inverse_if.slave (data_i/valid_i/ready_o in,
//               data_o/valid_o out)
// ---------------------------------------------------------------------------
module iir_inverse #(
    parameter int TIMECONSTANT = 9
) (
    input  logic          clk_i,
    input  logic          reset_i,
    iir_inverse_if.slave  bus
);

    localparam logic signed [25:0] COEF    = 26'(2 * TIMECONSTANT - 1);
    localparam logic        [10:0] DIVISOR = 11'(2 * TIMECONSTANT + 1);

    typedef enum logic [1:0] {IDLE, PREP, DIV, DONE} state_t;

    state_t             state;
    logic signed [15:0] y_cur;
    logic signed [15:0] y_prev;
    logic signed [15:0] x_prev;
    logic               neg;
    logic        [24:0] work;     // dividend in, quotient shifted in from the LSB
    logic        [9:0]  rem;      // partial remainder, always < DIVISOR
    logic        [4:0]  count;
    logic signed [15:0] data_q;
    logic               valid_q;
    logic               ready_q;

    // ---- numerator: all terms sign-extended to 26 bits, cannot overflow ----
    logic signed [25:0] x_ext;
    logic signed [25:0] c_times_x;
    logic signed [25:0] num;
    logic        [24:0] mag;

    assign x_ext     = {{10{x_prev[15]}}, x_prev};
    assign c_times_x = x_ext * COEF;
    assign num       = {{10{y_cur[15]}}, y_cur} + {{10{y_prev[15]}}, y_prev} - c_times_x;
    // |num| < 2^25, so dropping the top bit of the magnitude is lossless.
    assign mag       = 25'(num[25] ? -num : num);

    // ---- one restoring-divider step ----
    logic [10:0] rem_sh;
    logic        ge;
    logic [9:0]  rem_next;

    assign rem_sh   = {rem, work[24]};
    assign ge       = (rem_sh >= DIVISOR);
    // The result is below DIVISOR (<= 511), so 10 bits always hold it.
    assign rem_next = 10'(ge ? rem_sh - DIVISOR : rem_sh);

    // ---- sign reapplication and saturation ----
    logic signed [25:0] q_signed;
    logic signed [15:0] clamped;

    assign q_signed = neg ? -$signed({1'b0, work}) : $signed({1'b0, work});

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        clamped = q_signed[15:0];
        if (q_signed > 26'sd32767) begin
            clamped = 16'sh7FFF;
        end else if (q_signed < -26'sd32768) begin
            clamped = 16'sh8000;
        end
    end

    // ---- control and datapath registers ----
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state   <= IDLE;
            y_cur   <= '0;
            y_prev  <= '0;
            x_prev  <= '0;
            neg     <= 1'b0;
            work    <= '0;
            rem     <= '0;
            count   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.valid_i && ready_q) begin
                        y_cur   <= bus.data_i;
                        ready_q <= 1'b0;
                        state   <= PREP;
                    end
                end
                PREP: begin
                    neg   <= num[25];
                    work  <= mag;
                    rem   <= '0;
                    count <= 5'd24;
                    state <= DIV;
                end
                DIV: begin
                    work <= {work[23:0], ge};
                    rem  <= rem_next;
                    if (count == 5'd0) begin
                        state <= DONE;
                    end else begin
                        count <= count - 5'd1;
                    end
                end
                DONE: begin
                    data_q  <= clamped;
                    valid_q <= 1'b1;
                    ready_q <= 1'b1;
                    y_prev  <= y_cur;
                    x_prev  <= clamped;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.data_o  = data_q;
    assign bus.valid_o = valid_q;
    assign bus.ready_o = ready_q;

endmodule

// File: doc/iir_inverse.md
# iir_inverse

Inverse (equalising) first-order section for the `iir` filter: it recovers the original sample stream x[n] from the filtered stream y[n], where y[n] = (1+2K)·x[n] + (2K−1)·x[n−1] − y[n−1]. It sits after a `iir` instance, or on the receive side of a link whose transmitter applied that filter. It uses a valid/ready input handshake and a multi-cycle sequential divider, so it accepts one sample per 28 cycles.

## Interface
- `TIMECONSTANT`, default 9: filter constant K, legal range 1..255. Divisor D = 1+2K; feedback coefficient C = 2K−1.
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `reset_i`  in  1  synchronous, active-high reset.
- `data_i`  in  16  signed filtered sample y[n].
- `valid_i`  in  1  `data_i` is valid.
- `ready_o`  out  1  block can accept a sample; high only in IDLE.
- `data_o`  out  16  signed recovered sample x[n]; holds its value until the next result.
- `valid_o`  out  1  one-cycle pulse marking a new `data_o`.

## Operation
- History registers: y_prev (16b signed) and x_prev (16b signed), both 0 after reset.
- Accept: a sample is taken when `valid_i && ready_o` at a rising edge. `data_i` is captured into y_cur. `valid_i` is ignored in any other state and `data_i` is not sampled.
- Numerator, 26-bit signed: N = y_cur + y_prev − C·x_prev. All terms are sign-extended before the add, so there is no intermediate overflow (|N| < 2^25).
- Quotient: Q = N / D, truncated toward zero. Computed on the magnitude |N| with an unsigned restoring divider, 1 bit per cycle, 25 iterations. The sign is reapplied afterwards.
- Clamp: Q is saturated to [−32768, 32767] and the result is driven on `data_o`.
- History update happens at result time: y_prev ← y_cur and x_prev ← the clamped Q.
- State machine:
  - IDLE → PREP on accept.
  - PREP: one cycle. Form N, its sign, and |N|. Load iteration counter = 24. Go to DIV.
  - DIV: one quotient bit per cycle. The counter decrements. When counter = 0, that last step completes and the state goes to DONE.
  - DONE: one cycle. Apply sign, clamp, register `data_o`, pulse `valid_o`, update history. Go to IDLE.
- Reset, including mid-operation: state goes to IDLE, the divider aborts, the in-flight sample is discarded, history = 0, `data_o` = 0, `valid_o` = 0, `ready_o` = 1 from the cycle after reset deasserts. No `valid_o` is ever produced for an aborted sample.

## Timing
- Reset values: `data_o` = 0, `valid_o` = 0, `ready_o` = 1.
- Accept at edge t. PREP occupies cycle t..t+1. DIV occupies edges t+1..t+26, 25 steps. DONE is edge t+26..t+27.
- `valid_o` rises at edge t+27 and falls at edge t+28, so latency is 27 cycles.
- `ready_o` falls at edge t and rises again at edge t+27, the same cycle `valid_o` is high. The earliest next accept is edge t+28, giving a throughput of 1 sample per 28 cycles.
- `valid_i` held high continuously gives back-to-back accepts exactly every 28 cycles.
- `data_o` changes only at DONE→IDLE edges and at reset.
- There is no output backpressure. The consumer must take `data_o` during the `valid_o` pulse or later, before the next pulse.

## Test plan
- Reset: assert `reset_i` for 3 cycles mid-division. Required: `data_o` = 0, `valid_o` = 0, and `ready_o` = 1 on the cycle after deassert. No stray `valid_o` follows.
- Round trip, K = 9: drive y = 19, 17, 19, 17. Required: `data_o` = 1, 1, 1, 1. Each `valid_o` occurs exactly 27 cycles after its accept edge.
- Truncation toward zero, K = 9, after reset: y = −20 gives `data_o` = −1 (not −2). Then y = 20 gives N = 0 + 17 = 17, so `data_o` = 0.
- Large values, K = 9, after reset: y = 32767 gives 1724. Then y = 32767 gives N = 36226, so `data_o` = 1906.
- Handshake: hold `valid_i` high for 100 cycles with a changing `data_i`. Required: accepts only when `ready_o` = 1 (every 28 cycles), and exactly 4 `valid_o` pulses, each computed from the value present at its accept edge.
- Parameter K = 1: y = −32768 gives `data_o` = −10922. Then y = 32767 gives N = −1 + 10922 = 10921, so `data_o` = 3640.
